// File: rtl/wall_datapath.sv
// wall_datapath: wall position/gap, collision flag and an erase/paint pixel engine driving the VGA plotter (option macro: WALL_TRAIL_ERASE_EN).
// Latency: touched one cycle after wall_x qualifies; first pixel one cycle after an engine state is entered, then one pixel per cycle.
// Backpressure: none on the control side; step and redraw requests are latched and serviced whenever the engine is idle.
module wall_datapath #(
    parameter int         SCREEN_H = 120,
    parameter int         X_START  = 156,
    parameter int         X_END    = 0,
    parameter int         WALL_W   = 4,
    parameter int         GAP_H    = 24,
    parameter int         P_SIZE   = 4,
    parameter int         SPEED    = 1,
    parameter int         TICK_DIV = 833333,
    parameter logic [2:0] WALL_COL = 3'b111,
    parameter logic [2:0] BG_COL   = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] current,
    input  logic [6:0] gap_y,
    input  logic [7:0] player_x,
    input  logic [6:0] player_y,
    output logic       touched,
    output logic [7:0] wall_x,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy
);
    // Control codes this block reacts to; STOP (7) and every other code mean "hold".
    localparam logic [3:0] ST_READY = 4'd5;
    localparam logic [3:0] ST_MOVE  = 4'd6;
    localparam logic [3:0] ST_DRAW  = 4'd8;

    localparam logic [1:0] E_IDLE  = 2'd0;
    localparam logic [1:0] E_ERASE = 2'd1;
    localparam logic [1:0] E_PAINT = 2'd2;

    localparam int         TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [6:0] GAP_MAX = 7'(SCREEN_H - GAP_H);

    logic [7:0]        wall_x_q, old_x_q;
    logic [6:0]        gap_lat_q;
    logic              touched_q, step_pend_q;
    logic              dirty_q, dirty_d;
    logic [TICK_W-1:0] tick_q;
    logic [1:0]        eng_q, eng_d, step_state;
    logic [7:0]        col_q;
    logic [6:0]        row_q;
    logic [7:0]        x_q;
    logic [6:0]        y_q;
    logic [2:0]        colour_q;
    logic              plot_q;

    logic       is_ready, is_move, is_draw, eng_idle, tick_hit, step_go;
    logic [7:0] wall_step;
    logic [8:0] wx9, px9, py9, gl9;
    logic       overlap, in_gap, hit;
    logic [7:0] scan_base, scan_last;
    logic [2:0] pix_col;
    logic       gap_row, scan_end;

    assign is_ready = (current == ST_READY);
    assign is_move  = (current == ST_MOVE);
    assign is_draw  = (current == ST_DRAW);
    assign eng_idle = (eng_q == E_IDLE);
    assign tick_hit = (tick_q == TICK_W'(TICK_DIV - 1));
    assign step_go  = is_move && step_pend_q && !touched_q && eng_idle;

    // Saturating left step: never passes X_END, never wraps below zero.
    assign wall_step = ({1'b0, wall_x_q} >= 9'(X_END + SPEED)) ? (wall_x_q - 8'(SPEED)) : 8'(X_END);

`ifdef WALL_TRAIL_ERASE_EN
    // Nothing vacated when the wall is pinned at X_END, so go straight to painting.
    assign step_state = (wall_step == wall_x_q) ? E_PAINT : E_ERASE;
`else
    assign step_state = E_ERASE;
`endif

    // Collision test in 9 bits so wall_x+WALL_W-1 and player_x+P_SIZE-1 cannot wrap.
    assign wx9     = {1'b0, wall_x_q};
    assign px9     = {1'b0, player_x};
    assign py9     = {2'b00, player_y};
    assign gl9     = {2'b00, gap_lat_q};
    assign overlap = (wx9 <= px9 + 9'(P_SIZE - 1)) && (px9 <= wx9 + 9'(WALL_W - 1));
    assign in_gap  = (py9 >= gl9) && (py9 + 9'(P_SIZE) <= gl9 + 9'(GAP_H));
    assign hit     = (wall_x_q == 8'(X_END)) || (overlap && !in_gap);

    assign gap_row = ({1'b0, row_q} >= {1'b0, gap_lat_q}) &&
                     ({1'b0, row_q} <  {1'b0, gap_lat_q} + 8'(GAP_H));

    // Scan window and pixel colour for the current engine pass.
    always_comb begin
        scan_base = wall_x_q;
        scan_last = 8'(WALL_W - 1);
        pix_col   = gap_row ? BG_COL : WALL_COL;
        if (eng_q == E_ERASE) begin
`ifdef WALL_TRAIL_ERASE_EN
            scan_base = wall_x_q + 8'(WALL_W);
            scan_last = old_x_q - wall_x_q - 8'd1;
`else
            scan_base = old_x_q;
`endif
            pix_col   = BG_COL;
        end
    end

    assign scan_end = (col_q == scan_last) && (row_q == 7'(SCREEN_H - 1));

    // Engine sequencing; a step beats a redraw and absorbs it, DRAW while busy is remembered in dirty.
    always_comb begin
        eng_d   = eng_q;
        dirty_d = dirty_q;
        case (eng_q)
            E_IDLE: begin
                if (step_go) begin
                    eng_d   = step_state;
                    dirty_d = 1'b0;
                end else if (dirty_q || is_draw) begin
                    eng_d   = E_PAINT;
                    dirty_d = 1'b0;
                end
            end
            E_ERASE: begin
                if (scan_end) eng_d = E_PAINT;
                if (is_draw) dirty_d = 1'b1;
            end
            E_PAINT: begin
                if (scan_end) begin
                    if (dirty_q) dirty_d = 1'b0;
                    else         eng_d   = E_IDLE;
                end
                if (is_draw) dirty_d = 1'b1;
            end
            default: eng_d = E_IDLE;
        endcase
    end

    // Move tick, pending step, wall position and latched gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q      <= '0;
            step_pend_q <= 1'b0;
            wall_x_q    <= 8'(X_START);
            old_x_q     <= 8'(X_START);
            gap_lat_q   <= '0;
        end else begin
            tick_q <= tick_hit ? '0 : tick_q + 1'b1;
            if (is_ready) begin
                step_pend_q <= 1'b0;
                wall_x_q    <= 8'(X_START);
                gap_lat_q   <= (gap_y > GAP_MAX) ? GAP_MAX : gap_y;
            end else begin
                if (tick_hit)     step_pend_q <= 1'b1;
                else if (step_go) step_pend_q <= 1'b0;
                if (step_go) begin
                    old_x_q  <= wall_x_q;
                    wall_x_q <= wall_step;
                end
            end
        end
    end

    // Sticky collision flag, cleared only by READY.
    always_ff @(posedge clk) begin
        if (reset)         touched_q <= 1'b0;
        else if (is_ready) touched_q <= 1'b0;
        else if (hit)      touched_q <= 1'b1;
    end

    // Engine state, dirty flag and scan counters (column fastest, then row).
    always_ff @(posedge clk) begin
        if (reset) begin
            eng_q   <= E_IDLE;
            dirty_q <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            eng_q   <= eng_d;
            dirty_q <= dirty_d;
            if (eng_idle) begin
                col_q <= '0;
                row_q <= '0;
            end else if (col_q == scan_last) begin
                col_q <= '0;
                row_q <= (row_q == 7'(SCREEN_H - 1)) ? '0 : row_q + 7'd1;
            end else begin
                col_q <= col_q + 8'd1;
            end
        end
    end

    // Registered plot port: one pixel per active engine cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
        end else begin
            plot_q <= !eng_idle;
            if (!eng_idle) begin
                x_q      <= scan_base + col_q;
                y_q      <= row_q;
                colour_q <= pix_col;
            end
        end
    end

    assign touched = touched_q;
    assign wall_x  = wall_x_q;
    assign x       = x_q;
    assign y       = y_q;
    assign colour  = colour_q;
    assign plot    = plot_q;
    assign busy    = !eng_idle;

endmodule

// File: tb/tb_wall_datapath.sv
// Testbench for wall_datapath: randomized and directed control sequences against a queue-based pixel model.
// Latency: model advanced once per clock, outputs sampled 1 time unit after the rising edge.
// Backpressure: none; the bench only enters READY when the model says the engine is idle.
module tb_wall_datapath;
    localparam int H  = 8;
    localparam int W  = 2;
    localparam int GH = 2;
    localparam int XS = 10;
    localparam int XE = 0;
    localparam int SP = 1;
    localparam int PS = 1;
    localparam int TD = 4;
    localparam int WALL_C = 7;
    localparam int BG_C   = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] current;
    logic [6:0] gap_y;
    logic [7:0] player_x;
    logic [6:0] player_y;
    logic       touched;
    logic [7:0] wall_x;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;

    wall_datapath #(
        .SCREEN_H(H), .X_START(XS), .X_END(XE), .WALL_W(W), .GAP_H(GH),
        .P_SIZE(PS), .SPEED(SP), .TICK_DIV(TD), .WALL_COL(3'b111), .BG_COL(3'b000)
    ) dut (
        .clk(clk), .reset(reset), .current(current), .gap_y(gap_y),
        .player_x(player_x), .player_y(player_y), .touched(touched),
        .wall_x(wall_x), .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int plot_cnt = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected pixels are queued as whole passes when a job starts.
    typedef struct {
        int x;
        int y;
        int c;
        bit last_paint;
    } pix_t;

    pix_t q[$];
    int   m_wall, m_old, m_gap, m_tick, m_x, m_y, m_c;
    bit   m_touch, m_pend, m_dirty, m_plot;

    task automatic model_reset();
        m_wall = XS; m_old = XS; m_gap = 0; m_tick = 0;
        m_touch = 0; m_pend = 0; m_dirty = 0;
        m_plot = 0; m_x = 0; m_y = 0; m_c = 0;
        q.delete();
    endtask

    task automatic push_paint();
        pix_t p;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                p.x = m_wall + c;
                p.y = r;
                p.c = (r >= m_gap && r < m_gap + GH) ? BG_C : WALL_C;
                p.last_paint = (r == H - 1) && (c == W - 1);
                q.push_back(p);
            end
    endtask

    task automatic push_erase(input int lo, input int hi);
        pix_t p;
        for (int r = 0; r < H; r++)
            for (int c = lo; c <= hi; c++) begin
                p.x = c; p.y = r; p.c = BG_C; p.last_paint = 1'b0;
                q.push_back(p);
            end
    endtask

    function automatic bit touch_rule(input int wx, input int gl, input int px, input int py);
        bit ov, gp;
        ov = (wx <= px + PS - 1) && (px <= wx + W - 1);
        gp = (py >= gl) && (py + PS <= gl + GH);
        return (wx == XE) || (ov && !gp);
    endfunction

    task automatic model_edge();
        bit idle, tk, step, draw, ready, hit, pre_dirty;
        pix_t p;
        if (reset) begin
            model_reset();
            return;
        end
        idle      = (q.size() == 0);
        tk        = (m_tick == TD - 1);
        ready     = (current == 4'd5);
        draw      = (current == 4'd8);
        step      = (current == 4'd6) && m_pend && !m_touch && idle;
        hit       = touch_rule(m_wall, m_gap, int'(player_x), int'(player_y));
        pre_dirty = m_dirty;

        m_plot = 0;
        if (!idle) begin
            p = q.pop_front();
            m_plot = 1; m_x = p.x; m_y = p.y; m_c = p.c;
            if (p.last_paint && pre_dirty) begin
                m_dirty = 0;
                push_paint();
            end
            if (draw) m_dirty = 1;
        end

        m_touch = ready ? 1'b0 : (m_touch || hit);
        if (step)  m_pend = 0;
        if (tk)    m_pend = 1;
        if (ready) m_pend = 0;
        m_tick = tk ? 0 : m_tick + 1;

        if (ready) begin
            m_wall = XS;
            m_gap  = (int'(gap_y) > H - GH) ? H - GH : int'(gap_y);
        end
        if (step) begin
            m_old  = m_wall;
            m_wall = (m_wall - SP < XE) ? XE : m_wall - SP;
            m_dirty = 0;
`ifdef WALL_TRAIL_ERASE_EN
            push_erase(m_wall + W, m_old + W - 1);
`else
            push_erase(m_old, m_old + W - 1);
`endif
            push_paint();
        end else if (idle && (pre_dirty || draw)) begin
            m_dirty = 0;
            push_paint();
        end
    endtask

    task automatic compare();
        chk("wall_x",  int'(wall_x),  m_wall);
        chk("touched", int'(touched), int'(m_touch));
        chk("busy",    int'(busy),    int'(q.size() != 0));
        chk("plot",    int'(plot),    int'(m_plot));
        if (m_plot) begin
            chk("pix_x",      int'(x),      m_x);
            chk("pix_y",      int'(y),      m_y);
            chk("pix_colour", int'(colour), m_c);
        end
    endtask

    task automatic run_cycle();
        @(posedge clk);
        #1;
        model_edge();
        compare();
        if (plot) plot_cnt++;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        current = 4'd7;
        while ((busy || q.size() != 0) && n < 3000) begin
            run_cycle();
            n++;
        end
        if (n >= 3000) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        reset = 1'b1; current = 4'd0; gap_y = 7'd0; player_x = 8'd100; player_y = 7'd0;
        model_reset();
        run_cycles(2);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_colour", int'(colour), 0);
        reset = 1'b0;

        // READY with gap 3, then continuous MOVE
        current = 4'd5; gap_y = 7'd3;
        run_cycles(2);
        chk("ready_wall", int'(wall_x), XS);
        chk("ready_busy", int'(busy), 0);
        current = 4'd6;
        run_cycles(40);
        wait_idle();

        // Gap clamp: gap_y beyond the screen latches SCREEN_H-GAP_H
        current = 4'd5; gap_y = 7'd120;
        run_cycles(1);
        current = 4'd8;
        run_cycles(1);
        wait_idle();

        // Player in the wall's path outside the gap
        current = 4'd5; gap_y = 7'd3; player_x = 8'd9; player_y = 7'd0;
        run_cycles(1);
        current = 4'd6;
        run_cycles(60);
        chk("touch_set", int'(touched), 1);
        chk("touch_wall", int'(wall_x), 9);
        current = 4'd7;
        run_cycles(5);
        chk("touch_hold_stop", int'(touched), 1);
        wait_idle();
        current = 4'd5;
        run_cycles(1);
        chk("touch_clear", int'(touched), 0);

        // Player inside the gap: wall runs all the way to X_END
        player_y = 7'd3; current = 4'd6;
        run_cycles(420);
        chk("end_wall", int'(wall_x), XE);
        chk("end_touch", int'(touched), 1);
        run_cycles(20);
        chk("end_no_underflow", int'(wall_x), XE);
        wait_idle();

        // Two DRAW pulses during one PAINT give exactly one extra pass
        current = 4'd5;
        run_cycles(1);
        plot_cnt = 0;
        current = 4'd8; run_cycles(1);
        current = 4'd7; run_cycles(4);
        current = 4'd8; run_cycles(1);
        current = 4'd7; run_cycles(3);
        current = 4'd8; run_cycles(1);
        wait_idle();
        chk("draw_pixels", plot_cnt, 2 * W * H);

        // Reset in the middle of a PAINT pass
        current = 4'd8; run_cycles(1);
        current = 4'd7; run_cycles(5);
        reset = 1'b1;
        run_cycles(1);
        chk("midrst_plot", int'(plot), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_wall", int'(wall_x), XS);
        reset = 1'b0;

        // Randomized control sequences
        repeat (60) begin
            int sel, len;
            sel = int'($urandom_range(0, 9));
            len = int'($urandom_range(1, 12));
            player_x = 8'($urandom_range(0, 14));
            player_y = 7'($urandom_range(0, 7));
            gap_y    = 7'($urandom_range(0, 127));
            if (sel == 0) begin
                if (q.size() == 0 && !m_dirty) begin
                    current = 4'd5; len = 2;
                end else begin
                    current = 4'd7;
                end
            end else if (sel == 5) begin
                current = 4'd7;
            end else if (sel == 6) begin
                current = 4'd8; len = 1;
            end else if (sel == 7) begin
                current = 4'($urandom_range(9, 15));
            end else begin
                current = 4'd6;
            end
            run_cycles(len);
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
